// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch unit for the v6502 core.
// Loads the PC from the reset vector, fetches opcode plus operand bytes over a
// one-outstanding-read memory handshake, and presents one whole instruction at
// a time on a valid/ready port. A jump pulse redirects the stream and flushes
// whatever instruction was in progress.
module instr_fetch #(
    parameter logic [15:0] VECTOR_ADDR = 16'hFFFC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic [7:0]  i_mem_data,
    input  logic        i_mem_valid,
    output logic [7:0]  o_opcode,
    output logic [15:0] o_operand,
    output logic [1:0]  o_len,
    output logic [15:0] o_pc,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic        i_jump,
    input  logic [15:0] i_jump_addr
);

    typedef enum logic [2:0] {
        ST_VEC_LO,
        ST_VEC_HI,
        ST_OP,
        ST_ARG_LO,
        ST_ARG_HI,
        ST_PRESENT,
        ST_DRAIN
    } state_t;

    state_t      state_reg;
    logic [15:0] pc_reg;        // address of the next byte to fetch
    logic [15:0] mem_addr_reg;
    logic        mem_rd_reg;
    logic [7:0]  opcode_reg;
    logic [15:0] operand_reg;
    logic [1:0]  len_reg;
    logic [15:0] pc_out_reg;    // address of the opcode being assembled/presented
    logic        valid_reg;

    logic        mem_ack;
    logic [15:0] pc_inc;
    logic [1:0]  fetched_len;
    logic        jump_taken;

    // Instruction length from the opcode byte; every opcode gets a length,
    // earlier rules take priority over later ones.
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [1:0] len;
        if (op == 8'h20)
            len = 2'd3;
        else if (op == 8'h00 || op == 8'h40 || op == 8'h60)
            len = 2'd1;
        else if (op[1:0] == 2'b11)
            len = 2'd1;
        else if (op[3:0] == 4'h8 || op[3:0] == 4'hA)
            len = 2'd1;
        else if (op[3:0] == 4'hC || op[3:0] == 4'hD || op[3:0] == 4'hE)
            len = 2'd3;
        else if (op[3:0] == 4'h9 && op[4])
            len = 2'd3;
        else
            len = 2'd2;
        return len;
    endfunction

    // A data beat only counts when a read is actually outstanding.
    assign mem_ack     = mem_rd_reg & i_mem_valid;
    assign pc_inc      = pc_reg + 16'd1;
    assign fetched_len = op_len(i_mem_data);
    // Jumps are meaningless until the vector has been loaded.
    assign jump_taken  = i_jump && (state_reg != ST_VEC_LO) && (state_reg != ST_VEC_HI);

    // Fetch sequencer: all outputs are registered and change only here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_VEC_LO;
            pc_reg       <= 16'h0000;
            mem_addr_reg <= VECTOR_ADDR;
            mem_rd_reg   <= 1'b0;
            opcode_reg   <= 8'h00;
            operand_reg  <= 16'h0000;
            len_reg      <= 2'd0;
            pc_out_reg   <= 16'h0000;
            valid_reg    <= 1'b0;
        end else if (jump_taken) begin
            pc_reg      <= i_jump_addr;
            valid_reg   <= 1'b0;
            operand_reg <= 16'h0000;
            if (mem_rd_reg && !i_mem_valid) begin
                // Read still in flight: keep the request up and swallow its data.
                state_reg <= ST_DRAIN;
            end else begin
                // No read pending (or it completes now and is discarded).
                state_reg    <= ST_OP;
                mem_rd_reg   <= 1'b1;
                mem_addr_reg <= i_jump_addr;
            end
        end else begin
            case (state_reg)
                ST_VEC_LO: begin
                    if (!mem_rd_reg) begin
                        // First cycle out of reset: raise the vector read.
                        mem_rd_reg <= 1'b1;
                    end else if (mem_ack) begin
                        pc_reg[7:0]  <= i_mem_data;
                        mem_addr_reg <= VECTOR_ADDR + 16'd1;
                        state_reg    <= ST_VEC_HI;
                    end
                end
                ST_VEC_HI: begin
                    if (mem_ack) begin
                        pc_reg[15:8] <= i_mem_data;
                        mem_addr_reg <= {i_mem_data, pc_reg[7:0]};
                        state_reg    <= ST_OP;
                    end
                end
                ST_OP: begin
                    if (mem_ack) begin
                        opcode_reg  <= i_mem_data;
                        len_reg     <= fetched_len;
                        pc_out_reg  <= pc_reg;
                        pc_reg      <= pc_inc;
                        operand_reg <= 16'h0000;
                        if (fetched_len == 2'd1) begin
                            mem_rd_reg <= 1'b0;
                            valid_reg  <= 1'b1;
                            state_reg  <= ST_PRESENT;
                        end else begin
                            mem_addr_reg <= pc_inc;
                            state_reg    <= ST_ARG_LO;
                        end
                    end
                end
                ST_ARG_LO: begin
                    if (mem_ack) begin
                        operand_reg[7:0] <= i_mem_data;
                        pc_reg           <= pc_inc;
                        if (len_reg == 2'd3) begin
                            mem_addr_reg <= pc_inc;
                            state_reg    <= ST_ARG_HI;
                        end else begin
                            mem_rd_reg <= 1'b0;
                            valid_reg  <= 1'b1;
                            state_reg  <= ST_PRESENT;
                        end
                    end
                end
                ST_ARG_HI: begin
                    if (mem_ack) begin
                        operand_reg[15:8] <= i_mem_data;
                        pc_reg            <= pc_inc;
                        mem_rd_reg        <= 1'b0;
                        valid_reg         <= 1'b1;
                        state_reg         <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (i_ready) begin
                        // Accepted: start the next opcode read right away.
                        valid_reg    <= 1'b0;
                        mem_rd_reg   <= 1'b1;
                        mem_addr_reg <= pc_reg;
                        state_reg    <= ST_OP;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack) begin
                        mem_addr_reg <= pc_reg;
                        state_reg    <= ST_OP;
                    end
                end
                default: begin
                    state_reg  <= ST_VEC_LO;
                    mem_rd_reg <= 1'b0;
                    valid_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_addr = mem_addr_reg;
    assign o_mem_rd   = mem_rd_reg;
    assign o_opcode   = opcode_reg;
    assign o_operand  = operand_reg;
    assign o_len      = len_reg;
    assign o_pc       = pc_out_reg;
    assign o_valid    = valid_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run, all checked against a transaction-level model derived from memory.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] o_mem_addr;
    logic        o_mem_rd;
    logic [7:0]  i_mem_data;
    logic        i_mem_valid;
    logic [7:0]  o_opcode;
    logic [15:0] o_operand;
    logic [1:0]  o_len;
    logic [15:0] o_pc;
    logic        o_valid;
    logic        i_ready;
    logic        i_jump;
    logic [15:0] i_jump_addr;

    instr_fetch #(.VECTOR_ADDR(16'hFFFC)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_mem_addr  (o_mem_addr),
        .o_mem_rd    (o_mem_rd),
        .i_mem_data  (i_mem_data),
        .i_mem_valid (i_mem_valid),
        .o_opcode    (o_opcode),
        .o_operand   (o_operand),
        .o_len       (o_len),
        .o_pc        (o_pc),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .i_jump      (i_jump),
        .i_jump_addr (i_jump_addr)
    );

    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    logic [7:0] mem [0:65535];
    int         len_tab [0:255];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         fixed_wait = 0;   // -1 selects random wait 0..3
    bit         spurious_en = 1'b0;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] opnd;
        logic [1:0]  len;
        logic [15:0] pc;
        int          cyc;
    } acc_t;

    acc_t        acc_log [$];
    logic [15:0] rd_log  [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    bit waiting;
    int cnt;
    initial begin
        i_mem_valid = 1'b0;
        i_mem_data  = 8'h00;
        waiting     = 1'b0;
        cnt         = 0;
        forever begin
            @(posedge clk); #3;
            if (o_mem_rd) begin
                if (!waiting) begin
                    waiting = 1'b1;
                    cnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
                end
                if (cnt == 0) begin
                    i_mem_valid = 1'b1;
                    i_mem_data  = mem[o_mem_addr];
                    waiting     = 1'b0;
                end else begin
                    cnt--;
                    i_mem_valid = 1'b0;
                    i_mem_data  = 8'($urandom);
                end
            end else begin
                waiting     = 1'b0;
                i_mem_valid = spurious_en && ($urandom_range(0, 3) == 0);
                i_mem_data  = 8'($urandom);
            end
        end
    end

    // ---------------- reference model + compare process ----------------
    int          cyc = 0;
    int          vphase;
    logic [15:0] m_pc, fetch_ptr, drain_addr;
    bit          drain_pending;
    bit          prev_rd_wait, prev_hold, prev_jump, prev_accept;
    logic [15:0] prev_addr;
    logic [7:0]  sv_op;
    logic [15:0] sv_opnd, sv_pc;
    logic [1:0]  sv_len;
    int          idle_cnt;
    bit          ack, jump_eff, accept;
    int          exp_len;
    logic [15:0] exp_opnd;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_mem_rd",  {31'd0, o_mem_rd}, 32'd0);
            chk("rst_valid",   {31'd0, o_valid},  32'd0);
            chk("rst_opcode",  {24'd0, o_opcode}, 32'd0);
            chk("rst_operand", {16'd0, o_operand}, 32'd0);
            chk("rst_len",     {30'd0, o_len},    32'd0);
            chk("rst_pc",      {16'd0, o_pc},     32'd0);
            chk("rst_addr",    {16'd0, o_mem_addr}, 32'h0000FFFC);
            vphase = 0; drain_pending = 0;
            prev_rd_wait = 0; prev_hold = 0; prev_jump = 0; prev_accept = 0;
            idle_cnt = 0; m_pc = 16'h0; fetch_ptr = 16'h0;
        end else begin
            // ---- check the present output state ----
            if (prev_rd_wait) begin
                chk("rd_hold",   {31'd0, o_mem_rd}, 32'd1);
                chk("addr_hold", {16'd0, o_mem_addr}, {16'd0, prev_addr});
            end
            if (prev_hold) begin
                chk("stall_valid",   {31'd0, o_valid}, 32'd1);
                chk("stall_opcode",  {24'd0, o_opcode}, {24'd0, sv_op});
                chk("stall_operand", {16'd0, o_operand}, {16'd0, sv_opnd});
                chk("stall_len",     {30'd0, o_len}, {30'd0, sv_len});
                chk("stall_pc",      {16'd0, o_pc}, {16'd0, sv_pc});
            end
            if (prev_jump || prev_accept)
                chk("valid_drop", {31'd0, o_valid}, 32'd0);
            if (prev_jump)
                chk("jump_operand_clr", {16'd0, o_operand}, 32'd0);
            exp_len = len_tab[mem[m_pc]];
            if (o_valid) begin
                exp_opnd = 16'h0000;
                if (exp_len >= 2) exp_opnd[7:0]  = mem[16'(m_pc + 16'd1)];
                if (exp_len == 3) exp_opnd[15:8] = mem[16'(m_pc + 16'd2)];
                chk("no_read_while_valid", {31'd0, o_mem_rd}, 32'd0);
                chk("opcode",  {24'd0, o_opcode}, {24'd0, mem[m_pc]});
                chk("len",     {30'd0, o_len}, 32'(exp_len));
                chk("operand", {16'd0, o_operand}, {16'd0, exp_opnd});
                chk("pc",      {16'd0, o_pc}, {16'd0, m_pc});
                chk("all_bytes_read", {16'd0, fetch_ptr}, {16'd0, 16'(m_pc + 16'(exp_len))});
                idle_cnt = 0;
            end else begin
                idle_cnt++;
                if (idle_cnt > 100) begin
                    chk("progress_timeout", 32'd0, 32'd1);
                    idle_cnt = 0;
                end
            end

            // ---- predict what the coming edge does ----
            ack      = o_mem_rd && i_mem_valid;
            jump_eff = i_jump && (vphase == 2);
            accept   = o_valid && i_ready && !jump_eff;

            if (ack) begin
                rd_log.push_back(o_mem_addr);
                if (vphase == 0) begin
                    chk("read_vec_lo", {16'd0, o_mem_addr}, 32'h0000FFFC);
                    vphase = 1;
                end else if (vphase == 1) begin
                    chk("read_vec_hi", {16'd0, o_mem_addr}, 32'h0000FFFD);
                    vphase = 2;
                    m_pc = {mem[16'hFFFD], mem[16'hFFFC]};
                    fetch_ptr = m_pc;
                end else if (drain_pending) begin
                    chk("read_drain", {16'd0, o_mem_addr}, {16'd0, drain_addr});
                    drain_pending = 0;
                end else begin
                    chk("read_addr", {16'd0, o_mem_addr}, {16'd0, fetch_ptr});
                    chk("overfetch", (16'(fetch_ptr - m_pc) < 16'(exp_len)) ? 32'd1 : 32'd0, 32'd1);
                    fetch_ptr = fetch_ptr + 16'd1;
                end
            end
            if (jump_eff) begin
                if (o_mem_rd && !i_mem_valid && !drain_pending) begin
                    drain_pending = 1;
                    drain_addr = o_mem_addr;
                end
                m_pc = i_jump_addr;
                fetch_ptr = i_jump_addr;
                idle_cnt = 0;
            end
            if (accept) begin
                acc_log.push_back('{op: o_opcode, opnd: o_operand, len: o_len, pc: o_pc, cyc: cyc});
                $display("xfer pc=%h op=%h operand=%h len=%0d", o_pc, o_opcode, o_operand, o_len);
                m_pc = 16'(m_pc + 16'(exp_len));
                fetch_ptr = m_pc;
            end

            prev_rd_wait = o_mem_rd && !i_mem_valid;
            prev_addr    = o_mem_addr;
            prev_hold    = o_valid && !accept && !jump_eff;
            prev_jump    = jump_eff;
            prev_accept  = accept;
            sv_op = o_opcode; sv_opnd = o_operand; sv_len = o_len; sv_pc = o_pc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic rst_on();
        @(posedge clk); #2;
        rst_n = 1'b0;
    endtask

    task automatic rst_off();
        repeat (2) @(posedge clk);
        #2;
        rd_log.delete();
        acc_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic fill_random();
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
    endtask

    task automatic wait_accepts(input int n, input int budget, input string nm);
        for (int k = 0; k < budget && acc_log.size() < n; k++) begin
            @(posedge clk); #2;
        end
        chk({"accept_count_", nm}, (acc_log.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_read_at(input logic [15:0] addr, input int budget, input string nm);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(posedge clk); #2;
            seen = o_mem_rd && (o_mem_addr == addr);
        end
        chk({"reach_read_", nm}, {31'd0, seen}, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; i_ready = 1'b0; i_jump = 1'b0; i_jump_addr = 16'h0;
        for (int i = 0; i < 256; i++) begin
            int lo, l;
            lo = i % 16;
            l = 2;
            if (lo == 9 && ((i / 16) % 2) == 1) l = 3;
            if (lo >= 12 && lo <= 14) l = 3;
            if (lo == 8 || lo == 10) l = 1;
            if (i % 4 == 3) l = 1;
            if (i == 0 || i == 64 || i == 96) l = 1;
            if (i == 32) l = 3;
            len_tab[i] = l;
        end
        fill_random();

        // T1: vector fetch then LDA #$42
        fixed_wait = 0; i_ready = 1'b1;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
        rst_off();
        wait_accepts(1, 50, "t1");
        if (acc_log.size() >= 1 && rd_log.size() >= 4) begin
            chk("t1_op",   {24'd0, acc_log[0].op}, 32'hA9);
            chk("t1_opnd", {16'd0, acc_log[0].opnd}, 32'h0042);
            chk("t1_len",  {30'd0, acc_log[0].len}, 32'd2);
            chk("t1_pc",   {16'd0, acc_log[0].pc}, 32'h8000);
            chk("t1_rd0",  {16'd0, rd_log[0]}, 32'hFFFC);
            chk("t1_rd1",  {16'd0, rd_log[1]}, 32'hFFFD);
            chk("t1_rd2",  {16'd0, rd_log[2]}, 32'h8000);
            chk("t1_rd3",  {16'd0, rd_log[3]}, 32'h8001);
        end

        // T2: EA / 4C 34 12 / 0A back to back
        rst_on();
        mem[16'h8000] = 8'hEA; mem[16'h8001] = 8'h4C; mem[16'h8002] = 8'h34;
        mem[16'h8003] = 8'h12; mem[16'h8004] = 8'h0A;
        rst_off();
        wait_accepts(3, 60, "t2");
        if (acc_log.size() >= 3 && rd_log.size() >= 7) begin
            chk("t2_op0",   {24'd0, acc_log[0].op}, 32'hEA);
            chk("t2_len0",  {30'd0, acc_log[0].len}, 32'd1);
            chk("t2_pc0",   {16'd0, acc_log[0].pc}, 32'h8000);
            chk("t2_op1",   {24'd0, acc_log[1].op}, 32'h4C);
            chk("t2_opnd1", {16'd0, acc_log[1].opnd}, 32'h1234);
            chk("t2_len1",  {30'd0, acc_log[1].len}, 32'd3);
            chk("t2_pc1",   {16'd0, acc_log[1].pc}, 32'h8001);
            chk("t2_op2",   {24'd0, acc_log[2].op}, 32'h0A);
            chk("t2_len2",  {30'd0, acc_log[2].len}, 32'd1);
            chk("t2_pc2",   {16'd0, acc_log[2].pc}, 32'h8004);
            chk("t2_gap1",  32'(acc_log[1].cyc - acc_log[0].cyc), 32'd4);
            chk("t2_gap2",  32'(acc_log[2].cyc - acc_log[1].cyc), 32'd2);
            chk("t2_rd_op0", {16'd0, rd_log[2]}, 32'h8000);
            chk("t2_rd_op1", {16'd0, rd_log[3]}, 32'h8001);
            chk("t2_rd_op2", {16'd0, rd_log[6]}, 32'h8004);
        end

        // T3: 3-cycle memory waits and a 5-cycle consumer stall
        rst_on();
        fixed_wait = 3; i_ready = 1'b0;
        mem[16'h8000] = 8'h8D;
        rst_off();
        for (int k = 0; k < 100 && !o_valid; k++) begin
            @(posedge clk); #2;
        end
        chk("t3_valid_seen", {31'd0, o_valid}, 32'd1);
        repeat (5) @(posedge clk);
        #2;
        i_ready = 1'b1;
        wait_accepts(1, 20, "t3");
        if (acc_log.size() >= 1) begin
            chk("t3_len",     {30'd0, acc_log[0].len}, 32'd3);
            chk("t3_pc",      {16'd0, acc_log[0].pc}, 32'h8000);
            chk("t3_n_reads", 32'(rd_log.size()), 32'd5);
        end

        // T4: jump while the operand read at 8001 is outstanding
        rst_on();
        fixed_wait = 2; i_ready = 1'b1;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h55; mem[16'h9000] = 8'hEA;
        rst_off();
        wait_read_at(16'h8001, 100, "t4");
        i_jump = 1'b1; i_jump_addr = 16'h9000;
        @(posedge clk); #2;
        i_jump = 1'b0;
        wait_accepts(1, 100, "t4");
        if (acc_log.size() >= 1 && rd_log.size() >= 5) begin
            chk("t4_pc",     {16'd0, acc_log[0].pc}, 32'h9000);
            chk("t4_op",     {24'd0, acc_log[0].op}, 32'hEA);
            chk("t4_opnd",   {16'd0, acc_log[0].opnd}, 32'h0000);
            chk("t4_drain",  {16'd0, rd_log[3]}, 32'h8001);
            chk("t4_target", {16'd0, rd_log[4]}, 32'h9000);
        end

        // T5: JSR straddling the FFFF->0000 wrap
        rst_on();
        fixed_wait = 0;
        mem[16'hFFFC] = 8'hFE; mem[16'hFFFD] = 8'hFF;
        mem[16'hFFFE] = 8'h20; mem[16'hFFFF] = 8'h00;
        mem[16'h0000] = 8'hC0; mem[16'h0001] = 8'hEA;
        rst_off();
        wait_accepts(2, 60, "t5");
        if (acc_log.size() >= 2 && rd_log.size() >= 6) begin
            chk("t5_op",   {24'd0, acc_log[0].op}, 32'h20);
            chk("t5_opnd", {16'd0, acc_log[0].opnd}, 32'hC000);
            chk("t5_len",  {30'd0, acc_log[0].len}, 32'd3);
            chk("t5_pc",   {16'd0, acc_log[0].pc}, 32'hFFFE);
            chk("t5_next_rd", {16'd0, rd_log[5]}, 32'h0001);
            chk("t5_next_pc", {16'd0, acc_log[1].pc}, 32'h0001);
        end

        // T6: reset during the ARG_HI wait
        rst_on();
        fixed_wait = 3;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80; mem[16'h8000] = 8'h4C;
        rst_off();
        wait_read_at(16'h8002, 100, "t6");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_now", {31'd0, o_valid}, 32'd0);
        chk("t6_rd_now",    {31'd0, o_mem_rd}, 32'd0);
        rst_off();
        for (int k = 0; k < 50 && rd_log.size() < 1; k++) begin
            @(posedge clk); #2;
        end
        chk("t6_refetch_seen", (rd_log.size() >= 1) ? 32'd1 : 32'd0, 32'd1);
        if (rd_log.size() >= 1)
            chk("t6_refetch_addr", {16'd0, rd_log[0]}, 32'hFFFC);

        // T7: randomized traffic, jumps, spurious valids and occasional reset
        rst_on();
        fill_random();
        mem[16'hFFFC] = 8'($urandom); mem[16'hFFFD] = 8'($urandom);
        fixed_wait = -1; spurious_en = 1'b1;
        rst_off();
        begin
            int total;
            total = 0;
            for (int c = 0; c < 4000; c++) begin
                @(posedge clk); #2;
                i_ready = ($urandom_range(0, 3) != 0);
                if (i_jump) i_jump = 1'b0;
                else if ($urandom_range(0, 29) == 0) begin
                    i_jump = 1'b1;
                    i_jump_addr = 16'($urandom);
                end
                if ($urandom_range(0, 1499) == 0) begin
                    total += acc_log.size();
                    i_jump = 1'b0;
                    rst_n = 1'b0;
                    rst_off();
                end
            end
            i_jump = 1'b0;
            total += acc_log.size();
            chk("t7_enough_transfers", (total > 100) ? 32'd1 : 32'd0, 32'd1);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
